// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter.
// master drives the controls; slave (the counter) drives the status.
interface down_counter_if #(
   parameter int WIDTH = 2
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             en;
   logic [WIDTH-1:0] value;
   logic             borrow_out;
   logic             zero;
   logic             busy;

   modport master (
      output clear,
      output load,
      output load_value,
      output en,
      input  value,
      input  borrow_out,
      input  zero,
      input  busy
   );

   modport slave (
      input  clear,
      input  load,
      input  load_value,
      input  en,
      output value,
      output borrow_out,
      output zero,
      output busy
   );
endinterface

// File: rtl/down_counter.sv
// Down-counter with registered borrow, zero and busy flags.
// DOWN_COUNTER_SATURATE_EN: stop at 0 and make borrow_out sticky.
module down_counter #(
   parameter int               WIDTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input logic           clk,
   input logic           reset,
   down_counter_if.slave bus
);
   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] dec;
   logic             borrow_q;
   logic             borrow_d;
   logic             zero_q;
   logic             zero_d;
   logic             at_zero;
   logic             at_one;

   assign dec     = value_q - WIDTH'(1);
   assign at_zero = (value_q == '0);
   assign at_one  = (value_q == WIDTH'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         value_q  <= INIT;
         borrow_q <= 1'b0;
         zero_q   <= (INIT == '0);
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      zero_d  = zero_q;
`ifdef DOWN_COUNTER_SATURATE_EN
      borrow_d = borrow_q;
`else
      borrow_d = 1'b0;
`endif
      if (bus.clear) begin
         value_d  = '0;
         borrow_d = 1'b0;
         zero_d   = 1'b1;
         state_d  = IDLE;
      end else if (bus.load) begin
         value_d  = bus.load_value;
         borrow_d = 1'b0;
         zero_d   = (bus.load_value == '0);
         state_d  = (bus.load_value == '0) ? IDLE : COUNT;
      end else if (bus.en) begin
`ifdef DOWN_COUNTER_SATURATE_EN
         if (at_zero) begin
            borrow_d = 1'b1;
            zero_d   = 1'b1;
            state_d  = IDLE;
         end else begin
            value_d = dec;
            zero_d  = at_one;
            if (at_one)
               state_d = IDLE;
         end
`else
         // Wrap from 0 ends any count; busy stays low afterwards.
         value_d  = dec;
         borrow_d = at_zero;
         zero_d   = at_one;
         if (at_one || at_zero)
            state_d = IDLE;
`endif
      end
   end

   assign bus.value      = value_q;
   assign bus.borrow_out = borrow_q;
   assign bus.zero       = zero_q;
   assign bus.busy       = (state_q == COUNT);
endmodule

// File: tb/tb_down_counter.sv
// Directed and random checks of down_counter against a count model.
// Model follows DOWN_COUNTER_SATURATE_EN when that build is used.
module tb_down_counter;
   localparam int W    = 2;
   localparam int MOD  = 1 << W;
   localparam int INIT = 0;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   mv;
   int   mb;
   int   mbusy;

   down_counter_if #(.WIDTH(W)) bus ();

   down_counter #(
      .WIDTH(W),
      .INIT (W'(INIT))
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("value", 32'(bus.value), 32'(mv));
      check("borrow", 32'(bus.borrow_out), 32'(mb));
      check("zero", 32'(bus.zero), 32'(mv == 0));
      check("busy", 32'(bus.busy), 32'(mbusy));
   endtask

   task automatic model_reset();
      mv    = INIT;
      mb    = 0;
      mbusy = 0;
   endtask

   // One rising edge of the reference behaviour, on tb-driven inputs.
   task automatic model_edge();
      if (bus.clear) begin
         mv    = 0;
         mb    = 0;
         mbusy = 0;
      end else if (bus.load) begin
         mv    = int'(bus.load_value);
         mb    = 0;
         mbusy = (mv != 0);
      end else if (bus.en) begin
`ifdef DOWN_COUNTER_SATURATE_EN
         if (mv == 0) mb = 1;
         else mv = mv - 1;
`else
         mb = (mv == 0);
         mv = (mv + MOD - 1) % MOD;
`endif
         if (mv == 0 || mb == 1) mbusy = 0;
      end else begin
`ifndef DOWN_COUNTER_SATURATE_EN
         mb = 0;
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic c, input logic l,
                        input int lv, input logic e);
      bus.clear      = c;
      bus.load       = l;
      bus.load_value = W'(lv);
      bus.en         = e;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      clk   = 1'b0;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0);
      model_reset();
      #3;
      // Reset asserted mid-cycle, no edge needed.
      pulse_reset();
      step();

      // Load 2 then count through a wrap.
      drive(0, 1, 2, 0);
      step();
      drive(0, 0, 0, 1);
      repeat (4) step();

      // Clear beats load and en.
      drive(1, 1, 3, 1);
      step();

      // Load beats en.
      drive(0, 1, 1, 0);
      step();
      drive(0, 1, 0, 1);
      step();

      // Borrow pulse in flight cancelled by reset.
      drive(0, 0, 0, 1);
      step();
      pulse_reset();
      drive(0, 0, 0, 0);
      step();

      // Repeated en at 0 (sticky borrow in the saturating build).
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 1);
      repeat (3) step();
      drive(0, 1, 2, 0);
      step();
      drive(0, 0, 0, 0);
      step();

      // Random traffic with occasional async reset.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 15) == 0,
               $urandom_range(0, 3) == 0,
               int'($urandom_range(0, MOD - 1)),
               $urandom_range(0, 3) != 0);
         step();
         if ($urandom_range(0, 49) == 0)
            pulse_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Parameterised binary down-counter with a registered borrow flag. It is the decrementing counterpart of the team's 2-bit up-counter with carry_out.
- Used where a loaded count must be consumed one tick at a time, e.g. timeout and credit counting.
- Sits beside the up-counter, so carry/borrow pairs can be chained across stages.

Parameters:
- WIDTH, 2, counter width in bits (legal range 1..16).
- INIT, 0, value loaded on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted.
- clear  input  1  synchronous clear to 0; highest synchronous priority.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value captured when load=1.
- en  input  1  decrement enable.
- value  output  WIDTH  current count, registered.
- borrow_out  output  1  registered one-cycle pulse on a wrap from 0 to max.
- zero  output  1  registered; 1 when value==0.
- busy  output  1  registered; 1 while the count is nonzero after a load, until it reaches 0.

Behaviour:
- Reset: reset=0 asynchronously forces value=INIT, borrow_out=0, zero=(INIT==0), busy=0. Outputs hold while reset=0. Release is synchronous to the next rising clk.
- Priority per rising edge: clear > load > en > hold.
- clear=1:
  - value<=0, borrow_out<=0, zero<=1, busy<=0.
  - load and en are ignored in that cycle.
- load=1 (clear=0):
  - value<=load_value, borrow_out<=0, zero<=(load_value==0), busy<=(load_value!=0).
  - en is ignored in that cycle.
- en=1 (clear=0, load=0):
  - value<=value-1, computed modulo 2^WIDTH.
  - Decrement from 0: value<=2^WIDTH-1, borrow_out<=1 for exactly one cycle.
  - Decrement from 1: value<=0, zero<=1, busy<=0. No borrow.
- Hold (all controls 0): value is unchanged; borrow_out<=0.
- Latency: every output reflects the control inputs sampled at the previous rising edge. There is no combinational path from any input to any output.
- Consecutive borrows: with en held high, borrow_out pulses once per 2^WIDTH cycles. It is never held high for two consecutive cycles (for WIDTH>=2).
- WIDTH=1: borrow pulses every other cycle under constant en.
- Reset mid-count: state is discarded immediately. A borrow pulse in flight is cancelled (borrow_out goes to 0 asynchronously).
- busy state machine, two states:
  - IDLE (busy=0) -> COUNT on a load of a nonzero value.
  - COUNT -> IDLE on reaching 0 via en, or on clear, or on a load of 0.
  - A wrap through 0 with en=1 ends COUNT; busy stays 0 afterwards.

Optional Feature:
- Macro: DOWN_COUNTER_SATURATE_EN.
- Defined: en while value==0 leaves value at 0. borrow_out is instead a sticky underflow flag: it is set on the first en at 0 and cleared only by clear, load or reset.
- Undefined: wrap-around behaviour as specified above, with borrow_out as a one-cycle pulse.

Test Plan:
- Reset: WIDTH=2, INIT=0, reset=0 asserted mid-cycle -> value=0, zero=1, borrow_out=0, busy=0 immediately, with no clock edge required.
- Wrap: load_value=2, load for 1 cycle, then en=1 for 4 cycles -> value sequence 2,1,0,3,2. borrow_out=1 only in the cycle value=3. busy falls with value=0.
- Priority: clear=1, load=1, load_value=3, en=1 on the same edge -> value=0, zero=1, busy=0.
- Load over en: value=1, load=1, load_value=0, en=1 -> value=0, busy=0, borrow_out=0.
- Async reset mid-operation: en=1 with value=0, reset pulsed low before the edge -> borrow_out stays 0 and value=INIT.
- Saturate build (DOWN_COUNTER_SATURATE_EN defined): value=0, en=1 for 3 cycles -> value stays 0, borrow_out goes to 1 and stays 1 until load_value=2 is loaded, then returns to 0.
